// File: rtl/transmision_dac_pkg.sv
// Shared definitions for the DAC121S101-style serial transmitter: frame geometry,
// power-down codes, FSM encoding and the frame builder.
package transmision_dac_pkg;

    localparam int FRAME_W   = 16;
    localparam int DATA_W    = 12;
    localparam int BIT_CNT_W = 4;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CARGA    = 2'd1,
        DESPLAZA = 2'd2,
        ESPERA   = 2'd3
    } estado_t;

    // Two don't-care bits, then the power-down code, then the sample; MSB goes out first.
    function automatic logic [FRAME_W-1:0] arma_trama(input logic [1:0] pd,
                                                      input logic [DATA_W-1:0] dato);
        return {2'b00, pd, dato};
    endfunction

endpackage

// File: rtl/transmision_dac_if.sv
// Sample-source / DAC-pin bundle for the transmitter; master = sample source, slave = transmitter.
interface transmision_dac_if;
    import transmision_dac_pkg::*;

    logic [DATA_W-1:0] dato;
    logic              inicio;
    logic              data_out;
    logic              sclk;
    logic              cs;
    logic              busy;
    logic              listo;

    modport master (output dato, inicio,
                    input  data_out, sclk, cs, busy, listo);

    modport slave  (input  dato, inicio,
                    output data_out, sclk, cs, busy, listo);

endinterface

// File: rtl/transmision_dac_generador_sclk.sv
// SCLK generator: half-period counter that toggles SCLK every DIV enabled cycles and
// flags the cycle before each falling/rising SCLK edge. SCLK parks high when disabled.
module transmision_dac_generador_sclk #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic flanco_bajada,
    output logic flanco_subida
);

    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             sclk_reg;
    logic             wrap;

    assign wrap = en && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b1;
        end else if (!en) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b1;
        end else if (wrap) begin
            cnt_reg  <= '0;
            sclk_reg <= ~sclk_reg;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    assign sclk          = sclk_reg;
    assign flanco_bajada = wrap && sclk_reg;
    assign flanco_subida = wrap && !sclk_reg;

endmodule

// File: rtl/transmision_dac.sv
// Serial DAC transmitter: latches a 12-bit sample on Inicio, shifts a 16-bit frame out
// MSB-first under active-low CS, holds CS high for the SYNC gap, then pulses Listo.
module transmision_dac
    import transmision_dac_pkg::*;
#(
    parameter int         DIV     = 4,
    parameter logic [1:0] PD_MODE = PD_NORMAL
) (
    input  logic              clk,
    input  logic              rst,
    transmision_dac_if.slave  bus
);

    localparam int              ESPERA_CICLOS = 2 * DIV;
    localparam int              ESP_W         = $clog2(ESPERA_CICLOS);
    localparam logic [ESP_W-1:0] ESP_MAX      = ESP_W'(ESPERA_CICLOS - 1);

    estado_t              estado_reg;
    estado_t              estado_next;
    logic [FRAME_W-1:0]   trama_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [ESP_W-1:0]     espera_cnt_reg;
    logic                 listo_reg;

    logic sclk_en;
    logic sclk;
    logic flanco_bajada;
    logic flanco_subida;
    logic ultimo_flanco;
    logic espera_fin;
    logic unused_flanco_bajada;

    transmision_dac_generador_sclk #(.DIV(DIV)) u_generador_sclk (
        .clk           (clk),
        .rst           (rst),
        .en            (sclk_en),
        .sclk          (sclk),
        .flanco_bajada (flanco_bajada),
        .flanco_subida (flanco_subida)
    );

    // Data only moves on rising SCLK edges, so the falling strobe has no consumer here.
    assign unused_flanco_bajada = flanco_bajada;

    assign ultimo_flanco = flanco_subida && (bit_cnt_reg == '0);
    assign espera_fin    = (espera_cnt_reg == ESP_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_reg <= IDLE;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            IDLE:     if (bus.inicio)    estado_next = CARGA;
            CARGA:                       estado_next = DESPLAZA;
            DESPLAZA: if (ultimo_flanco) estado_next = ESPERA;
            ESPERA:   if (espera_fin)    estado_next = IDLE;
            default:                     estado_next = IDLE;
        endcase
    end

    // Busy stays up through the Listo cycle even though the FSM is already back in IDLE.
    always_comb begin
        bus.cs       = 1'b1;
        bus.data_out = 1'b0;
        bus.busy     = listo_reg;
        sclk_en      = 1'b0;
        case (estado_reg)
            CARGA: begin
                bus.busy = 1'b1;
            end
            DESPLAZA: begin
                bus.cs       = 1'b0;
                bus.data_out = trama_reg[FRAME_W-1];
                bus.busy     = 1'b1;
                sclk_en      = 1'b1;
            end
            ESPERA: begin
                bus.busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.sclk  = sclk;
    assign bus.listo = listo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trama_reg      <= '0;
            bit_cnt_reg    <= '0;
            espera_cnt_reg <= '0;
            listo_reg      <= 1'b0;
        end else begin
            listo_reg      <= (estado_reg == ESPERA) && espera_fin;
            espera_cnt_reg <= (estado_reg == ESPERA) ? espera_cnt_reg + 1'b1 : '0;
            case (estado_reg)
                IDLE: begin
                    if (bus.inicio) trama_reg <= arma_trama(PD_MODE, bus.dato);
                end
                CARGA: begin
                    bit_cnt_reg <= BIT_CNT_W'(FRAME_W - 1);
                end
                DESPLAZA: begin
                    if (flanco_subida && (bit_cnt_reg != '0)) begin
                        trama_reg   <= trama_reg << 1;
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_transmision_dac.sv
// Bench for transmision_dac: three instances (DIV=4/PD=00, DIV=4/PD=11, DIV=1/PD=00),
// each observed by a DAC-side model that captures the word on SCLK falls.
module tb_transmision_dac;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [11:0] dato_r   [3];
    logic        inicio_r [3];

    wire        cs_w       [3];
    wire        sclk_w     [3];
    wire        data_w     [3];
    wire        busy_w     [3];
    wire        listo_w    [3];
    wire [15:0] word_w     [3];
    wire [31:0] falls_w    [3];
    wire [31:0] last_falls_w [3];
    wire [31:0] fall_cyc_w [3];
    wire [31:0] rise_cyc_w [3];
    wire [31:0] frames_w   [3];
    wire [31:0] listo_cnt_w [3];
    wire [31:0] listo_cyc_w [3];
    wire [31:0] viol_w     [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int         DIV_G = (gi == 2) ? 1 : 4;
        localparam logic [1:0] PD_G  = (gi == 1) ? 2'b11 : 2'b00;

        transmision_dac_if bus_if ();

        assign bus_if.dato   = dato_r[gi];
        assign bus_if.inicio = inicio_r[gi];

        transmision_dac #(.DIV(DIV_G), .PD_MODE(PD_G)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_if)
        );

        assign cs_w[gi]    = bus_if.cs;
        assign sclk_w[gi]  = bus_if.sclk;
        assign data_w[gi]  = bus_if.data_out;
        assign busy_w[gi]  = bus_if.busy;
        assign listo_w[gi] = bus_if.listo;

        // DAC model plus protocol watch: samples DIN on SCLK falls inside CS-low windows.
        logic [15:0] word = '0;
        logic [15:0] last_word = '0;
        int falls = 0, last_falls = 0, fall_cyc = 0, rise_cyc = 0;
        int frames = 0, listo_cnt = 0, listo_cyc = 0, viol = 0;
        logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_data = 1'b0;

        always @(negedge clk) begin
            if (prev_cs && !bus_if.cs) begin
                fall_cyc = cyc;
                falls    = 0;
                word     = '0;
            end
            if (!bus_if.cs && prev_sclk && !bus_if.sclk) begin
                word  = {word[14:0], prev_data};
                falls = falls + 1;
            end
            if (!prev_cs && bus_if.cs) begin
                rise_cyc   = cyc;
                last_word  = word;
                last_falls = falls;
                frames     = frames + 1;
            end
            if (bus_if.listo) begin
                listo_cnt = listo_cnt + 1;
                listo_cyc = cyc;
            end
            if (prev_sclk && !bus_if.sclk && (bus_if.data_out !== prev_data)) viol = viol + 1;
            if (prev_cs && bus_if.cs && (bus_if.sclk !== prev_sclk)) viol = viol + 1;
            prev_cs   = bus_if.cs;
            prev_sclk = bus_if.sclk;
            prev_data = bus_if.data_out;
        end

        assign word_w[gi]       = last_word;
        assign falls_w[gi]      = falls;
        assign last_falls_w[gi] = last_falls;
        assign fall_cyc_w[gi]   = fall_cyc;
        assign rise_cyc_w[gi]   = rise_cyc;
        assign frames_w[gi]     = frames;
        assign listo_cnt_w[gi]  = listo_cnt;
        assign listo_cyc_w[gi]  = listo_cyc;
        assign viol_w[gi]       = viol;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start(input int d, input logic [11:0] v, output int acc);
        dato_r[d]   = v;
        inicio_r[d] = 1'b1;
        acc         = cyc + 1;
        tick();
        inicio_r[d] = 1'b0;
    endtask

    task automatic wait_listo(input int d, input int base, input int budget);
        int n;
        n = 0;
        while ((listo_cnt_w[d] == 32'(base)) && (n < budget)) begin
            tick();
            n++;
        end
        check($sformatf("listo_seen dut%0d", d), listo_cnt_w[d] - 32'(base), 32'd1);
    endtask

    typedef struct {
        int          dut;
        logic [11:0] dato;
        logic [15:0] word;
        int          cs_low;
        int          listo_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, acc2, base_l, base_f, n, prev_listo, prev_rise;

        vecs[0] = '{0, 12'hA5C, 16'h0A5C, 128, 137};
        vecs[1] = '{1, 12'hFFF, 16'h3FFF, 128, 137};
        vecs[2] = '{1, 12'h000, 16'h3000, 128, 137};
        vecs[3] = '{2, 12'hA5C, 16'h0A5C,  32,  35};
        vecs[4] = '{0, 12'hFFF, 16'h0FFF, 128, 137};
        vecs[5] = '{0, 12'h000, 16'h0000, 128, 137};
        vecs[6] = '{2, 12'h5A3, 16'h05A3,  32,  35};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dato_r[i]   = '0;
            inicio_r[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset cs dut%0d", i),    32'(cs_w[i]),    32'd1);
            check($sformatf("reset sclk dut%0d", i),  32'(sclk_w[i]),  32'd1);
            check($sformatf("reset data dut%0d", i),  32'(data_w[i]),  32'd0);
            check($sformatf("reset busy dut%0d", i),  32'(busy_w[i]),  32'd0);
            check($sformatf("reset listo dut%0d", i), 32'(listo_w[i]), 32'd0);
        end
        rst = 1'b0;
        repeat (2) tick();

        // Table of single frames on each instance.
        for (int i = 0; i < 7; i++) begin
            int d;
            d      = vecs[i].dut;
            base_l = listo_cnt_w[d];
            base_f = frames_w[d];
            start(d, vecs[i].dato, acc);
            check($sformatf("v%0d busy_after_accept", i), 32'(busy_w[d]), 32'd1);
            wait_listo(d, base_l, 400);
            check($sformatf("v%0d word", i),       32'(word_w[d]), 32'(vecs[i].word));
            check($sformatf("v%0d falls", i),      last_falls_w[d], 32'd16);
            check($sformatf("v%0d cs_fall_lat", i), fall_cyc_w[d] - 32'(acc), 32'd1);
            check($sformatf("v%0d cs_low", i),     rise_cyc_w[d] - fall_cyc_w[d], 32'(vecs[i].cs_low));
            check($sformatf("v%0d listo_lat", i),  listo_cyc_w[d] - 32'(acc), 32'(vecs[i].listo_lat));
            check($sformatf("v%0d busy_in_listo", i), 32'(busy_w[d]), 32'd1);
            check($sformatf("v%0d frames", i),     frames_w[d] - 32'(base_f), 32'd1);
            tick();
            check($sformatf("v%0d busy_idle", i),  32'(busy_w[d]), 32'd0);
            check($sformatf("v%0d listo_1cyc", i), 32'(listo_w[d]), 32'd0);
            tick();
        end

        // Second request and Dato change mid-frame are ignored.
        base_l = listo_cnt_w[0];
        base_f = frames_w[0];
        start(0, 12'hA5C, acc);
        repeat (40) tick();
        dato_r[0]   = 12'h123;
        inicio_r[0] = 1'b1;
        tick();
        inicio_r[0] = 1'b0;
        wait_listo(0, base_l, 400);
        check("busy_req word", 32'(word_w[0]), 32'h0A5C);
        check("busy_req listo_lat", listo_cyc_w[0] - 32'(acc), 32'd137);
        repeat (160) tick();
        check("busy_req frames", frames_w[0] - 32'(base_f), 32'd1);
        check("busy_req listos", listo_cnt_w[0] - 32'(base_l), 32'd1);

        // Inicio present only on the edge that raises Listo is dropped (DIV=1).
        base_l = listo_cnt_w[2];
        base_f = frames_w[2];
        start(2, 12'h0F0, acc);
        n = 0;
        while ((cyc != acc + 34) && (n < 100)) begin
            tick();
            n++;
        end
        check("listo_edge reached", 32'(cyc - acc), 32'd34);
        inicio_r[2] = 1'b1;
        dato_r[2]   = 12'h00F;
        tick();
        inicio_r[2] = 1'b0;
        check("listo_edge listo", 32'(listo_w[2]), 32'd1);
        repeat (60) tick();
        check("listo_edge frames", frames_w[2] - 32'(base_f), 32'd1);
        check("listo_edge word", 32'(word_w[2]), 32'h00F0);

        // Inicio raised during the Listo cycle is taken on the following edge.
        base_l = listo_cnt_w[2];
        start(2, 12'h3C3, acc);
        wait_listo(2, base_l, 100);
        inicio_r[2] = 1'b1;
        dato_r[2]   = 12'h111;
        acc2        = cyc + 1;
        tick();
        inicio_r[2] = 1'b0;
        check("listo_cycle first word", 32'(word_w[2]), 32'h03C3);
        wait_listo(2, base_l + 1, 100);
        check("listo_cycle cs_fall_lat", fall_cyc_w[2] - 32'(acc2), 32'd1);
        check("listo_cycle acc_gap", 32'(acc2 - acc), 32'd36);
        check("listo_cycle second word", 32'(word_w[2]), 32'h0111);
        repeat (4) tick();

        // Inicio held high: back-to-back frames with ramping data.
        base_l     = listo_cnt_w[0];
        base_f     = frames_w[0];
        prev_listo = 0;
        prev_rise  = 0;
        dato_r[0]   = 12'h000;
        inicio_r[0] = 1'b1;
        acc         = cyc + 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            wait_listo(0, base_l + i, 400);
            check($sformatf("b2b%0d word", i),  32'(word_w[0]), 32'(i));
            check($sformatf("b2b%0d falls", i), last_falls_w[0], 32'd16);
            if (i == 0) begin
                check("b2b0 listo_lat", listo_cyc_w[0] - 32'(acc), 32'd137);
            end else begin
                check($sformatf("b2b%0d period", i), listo_cyc_w[0] - 32'(prev_listo), 32'd138);
                check($sformatf("b2b%0d gap_ge8", i),
                      32'((fall_cyc_w[0] - 32'(prev_rise)) >= 32'd8), 32'd1);
            end
            prev_listo = listo_cyc_w[0];
            prev_rise  = rise_cyc_w[0];
            if (i < 2) dato_r[0] = 12'(i + 1);
            else       inicio_r[0] = 1'b0;
        end
        repeat (160) tick();
        check("b2b frames", frames_w[0] - 32'(base_f), 32'd3);
        check("b2b listos", listo_cnt_w[0] - 32'(base_l), 32'd3);

        // Asynchronous reset in the middle of a frame.
        base_l = listo_cnt_w[0];
        start(0, 12'h5A5, acc);
        n = 0;
        while ((falls_w[0] < 32'd8) && (n < 300)) begin
            tick();
            n++;
        end
        check("rst_mid reached_bit7", 32'(falls_w[0] >= 32'd8), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid cs",   32'(cs_w[0]),   32'd1);
        check("rst_mid sclk", 32'(sclk_w[0]), 32'd1);
        check("rst_mid data", 32'(data_w[0]), 32'd0);
        check("rst_mid busy", 32'(busy_w[0]), 32'd0);
        tick();
        rst = 1'b0;
        repeat (200) tick();
        check("rst_mid no_listo", listo_cnt_w[0] - 32'(base_l), 32'd0);
        base_l = listo_cnt_w[0];
        start(0, 12'h321, acc);
        wait_listo(0, base_l, 400);
        check("rst_mid clean word",  32'(word_w[0]), 32'h0321);
        check("rst_mid clean falls", last_falls_w[0], 32'd16);
        check("rst_mid clean lat",   listo_cyc_w[0] - 32'(acc), 32'd137);
        repeat (4) tick();

        for (int i = 0; i < 3; i++) begin
            check($sformatf("protocol dut%0d", i), viol_w[i], 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
